// File: rtl/arbiter_roundrobin_modulo3.sv
// Round-robin arbiter for three requesters with a modulo-3 priority pointer,
// a bounded hold time and a one-cycle idle gap between owners.
module arbiter_roundrobin_modulo3 #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clockpulse,
    input  logic       clear_,
    input  logic [2:0] request,
    output logic [2:0] grant,
    output logic [1:0] grant_index,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RECOVER
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);
    localparam logic [1:0]       NO_OWNER   = 2'b11;

    state_e           state_q, state_d;
    logic [1:0]       pointer_q, pointer_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       index_q, index_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [1:0]       scan_idx;
    logic             owner_req;
    logic             hold_expired;

    function automatic logic [1:0] next_mod3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Scan pointer, pointer+1, pointer+2 (mod 3); the first active request wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        scan_idx   = pointer_q;
        for (int k = 0; k < 3; k++) begin
            if (!pick_valid && request[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = next_mod3(scan_idx);
        end
    end

    // Owner's request bit taken through the one-hot grant, so no index is ever out of range.
    assign owner_req    = |(request & grant_q);
    assign hold_expired = (hold_q == HOLD_LIMIT);

    // NOTE: all state updates on the falling edge; reset is synchronous, so it lives inside the clocked block.
    always_ff @(negedge clockpulse) begin
        if (!clear_) begin
            state_q   <= ST_IDLE;
            pointer_q <= 2'd0;
            hold_q    <= '0;
            grant_q   <= 3'b000;
            index_q   <= NO_OWNER;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        hold_d    = hold_q;
        unique case (state_q)
            ST_IDLE, ST_RECOVER: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    hold_d  = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req || hold_expired) begin
                    state_d   = ST_RECOVER;
                    pointer_d = next_mod3(index_q);
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pointer_d = 2'd0;
                hold_d    = '0;
            end
        endcase
    end

    // Registered outputs follow the next state; an owner keeps its grant while staying in GRANT.
    always_comb begin
        grant_d   = 3'b000;
        index_d   = NO_OWNER;
        busy_d    = 1'b0;
        timeout_d = (state_q == ST_GRANT) && owner_req && hold_expired;
        if (state_d == ST_GRANT) begin
            busy_d = 1'b1;
            if (state_q == ST_GRANT) begin
                grant_d = grant_q;
                index_d = index_q;
            end else begin
                grant_d = 3'b001 << pick_idx;
                index_d = pick_idx;
            end
        end
    end

    assign grant       = grant_q;
    assign grant_index = index_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_arbiter_roundrobin_modulo3.sv
// Bench for arbiter_roundrobin_modulo3: directed scenarios followed by random
// requests, every edge compared against an owner/hold/pointer reference model.
module tb_arbiter_roundrobin_modulo3;

    localparam int HOLD_MAX = 4;

    logic       clockpulse;
    logic       clear_;
    logic [2:0] request;
    logic [2:0] grant;
    logic [1:0] grant_index;
    logic       busy;
    logic       timeout;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: who owns the resource, for how long, and where priority starts.
    int m_owner;
    int m_held;
    int m_ptr;
    bit m_timeout;

    arbiter_roundrobin_modulo3 #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (4)
    ) dut (
        .clockpulse (clockpulse),
        .clear_     (clear_),
        .request    (request),
        .grant      (grant),
        .grant_index(grant_index),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clockpulse = 1'b1;
    always #5 clockpulse = ~clockpulse;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_step(input logic rst_n_in, input logic [2:0] req);
        m_timeout = 1'b0;
        if (!rst_n_in) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner] || m_held == HOLD_MAX) begin
                m_timeout = req[m_owner];
                m_ptr     = (m_owner + 1) % 3;
                m_owner   = -1;
                m_held    = 0;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 3]) begin
                    m_owner = (m_ptr + k) % 3;
                    m_held  = 1;
                end
            end
        end
    endtask

    // Drive inputs, let one falling edge pass, then compare every output with the model.
    task automatic step(input logic rst_n_in, input logic [2:0] req);
        logic [2:0] exp_grant;
        logic [1:0] exp_idx;
        clear_  = rst_n_in;
        request = req;
        @(negedge clockpulse);
        model_step(rst_n_in, req);
        #1;
        exp_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        exp_idx   = (m_owner < 0) ? 2'b11 : 2'(m_owner);
        check("grant", 8'(grant), 8'(exp_grant));
        check("grant_index", 8'(grant_index), 8'(exp_idx));
        check("busy", 8'(busy), 8'(m_owner >= 0));
        check("timeout", 8'(timeout), 8'(m_timeout));
        check("onehot0", 8'($onehot0(grant)), 8'd1);
    endtask

    initial begin
        logic [2:0] fair_seq [16];
        logic       fair_to  [16];
        logic [2:0] rnd_req;

        fair_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                     3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                     3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
        fair_to  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

        m_owner   = -1;
        m_held    = 0;
        m_ptr     = 0;
        m_timeout = 1'b0;
        clear_    = 1'b0;
        request   = 3'b000;

        // T1: reset held for two edges with all requests active.
        step(1'b0, 3'b111);
        step(1'b0, 3'b111);
        check("t1_grant", 8'(grant), 8'h00);
        check("t1_idx", 8'(grant_index), 8'h03);

        // T2: single requester, release after three cycles, pointer lands on 2.
        step(1'b1, 3'b010);
        check("t2_grant", 8'(grant), 8'h02);
        check("t2_idx", 8'(grant_index), 8'h01);
        step(1'b1, 3'b010);
        step(1'b1, 3'b010);
        step(1'b1, 3'b000);
        check("t2_release", 8'(grant), 8'h00);
        step(1'b1, 3'b111);
        check("t2_ptr2", 8'(grant), 8'h04);

        // T3: constant full request rotates owners with forced releases.
        step(1'b0, 3'b000);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3'b111);
            check("t3_grant", 8'(grant), 8'(fair_seq[i]));
            check("t3_timeout", 8'(timeout), 8'(fair_to[i]));
        end

        // T4: owner 2 releases, pointer wraps to 0.
        step(1'b0, 3'b000);
        step(1'b1, 3'b100);
        check("t4_owner2", 8'(grant), 8'h04);
        step(1'b1, 3'b000);
        step(1'b1, 3'b101);
        check("t4_wrap", 8'(grant), 8'h01);

        // T5: reset in the middle of a grant.
        step(1'b0, 3'b000);
        step(1'b1, 3'b010);
        step(1'b0, 3'b111);
        check("t5_reset", 8'(grant), 8'h00);
        step(1'b1, 3'b100);
        check("t5_after", 8'(grant), 8'h04);

        // T6: owner drops while another raises on the same edge.
        step(1'b0, 3'b000);
        step(1'b1, 3'b001);
        step(1'b1, 3'b010);
        check("t6_gap", 8'(grant), 8'h00);
        step(1'b1, 3'b010);
        check("t6_next", 8'(grant), 8'h02);

        // Random requests, mostly held steady so holds run to completion, with rare resets.
        rnd_req = 3'b000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) < 3) rnd_req = 3'($urandom_range(7));
            step(($urandom_range(59) != 0), rnd_req);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
